// File: rtl/mac_pkg.sv
// Shared constants and helpers for the mac2 issue path.
package mac_pkg;

  localparam int unsigned DATA_W            = 32;
  // 10 cycles of mac2 plus 5 cycles of the final sum stage.
  localparam int unsigned MAC2_CORE_LATENCY = 15;

  // Width of a counter that must hold the values 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mac_result_fifo.sv
// Synchronous first-word-fall-through result FIFO with occupancy count.
// A write while full is dropped; a read while empty is ignored.
module mac_result_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 32
) (
  input  logic                              clock,
  input  logic                              resetn,
  input  logic                              wr_en,
  input  logic [DATA_W-1:0]                 wr_data,
  input  logic                              rd_en,
  output logic [DATA_W-1:0]                 rd_data,
  output logic [mac_pkg::cnt_w(DEPTH)-1:0]  count,
  output logic                              full,
  output logic                              empty
);
  import mac_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mac2_cyv_issuer.sv
// Initiator for the free-running fixed-latency mac2 core: accepts operand
// tuples, launches them, tracks them with a valid pipe, and queues results
// in a credit-protected FWFT FIFO presented downstream with valid/ready.
module mac2_cyv_issuer #(
  parameter int unsigned DATA_W     = mac_pkg::DATA_W,
  parameter int unsigned LATENCY    = mac_pkg::MAC2_CORE_LATENCY,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              ivalid,
  output logic              oready,
  input  logic [DATA_W-1:0] datainC,
  input  logic [DATA_W-1:0] datainA0,
  input  logic [DATA_W-1:0] datainB0,
  input  logic [DATA_W-1:0] datainA1,
  input  logic [DATA_W-1:0] datainB1,
  output logic [DATA_W-1:0] core_c,
  output logic [DATA_W-1:0] core_a0,
  output logic [DATA_W-1:0] core_b0,
  output logic [DATA_W-1:0] core_a1,
  output logic [DATA_W-1:0] core_b1,
  input  logic [DATA_W-1:0] core_q,
  output logic              ovalid,
  input  logic              iready,
  output logic [DATA_W-1:0] dataout,
  output logic              busy,
  output logic              overflow_err
);
  import mac_pkg::*;

  localparam int unsigned CW = cnt_w(FIFO_DEPTH);

  logic [CW-1:0]    used;
  logic             accept;
  logic             pop;
  logic [LATENCY:0] vpipe;
  logic             fifo_wr;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;

  // Credits are reserved at accept, so the FIFO always has room when a
  // result lands; oready depends only on the registered credit count.
  assign oready  = (used < CW'(FIFO_DEPTH));
  assign accept  = ivalid & oready;
  assign pop     = ovalid & iready;
  assign ovalid  = ~fifo_empty;
  assign busy    = (used != '0);
  assign fifo_wr = vpipe[LATENCY];

  // Credit counter: in-flight ops plus queued results.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      used <= '0;
    end else begin
      unique case ({accept, pop})
        2'b10:   used <= used + CW'(1);
        2'b01:   used <= used - CW'(1);
        default: used <= used;
      endcase
    end
  end

  // Issue registers feeding the core; hold their value when nothing is accepted.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      core_c  <= '0;
      core_a0 <= '0;
      core_b0 <= '0;
      core_a1 <= '0;
      core_b1 <= '0;
    end else if (accept) begin
      core_c  <= datainC;
      core_a0 <= datainA0;
      core_b0 <= datainB0;
      core_a1 <= datainA1;
      core_b1 <= datainB1;
    end
  end

  // Valid pipe shadowing the core; the top bit marks core_q as a real result.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) vpipe <= '0;
    else         vpipe <= {vpipe[LATENCY-1:0], accept};
  end

  // Sticky error flag for a result landing in a full FIFO.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                   overflow_err <= 1'b0;
    else if (fifo_wr && fifo_full) overflow_err <= 1'b1;
  end

  mac_result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .wr_en   (fifo_wr),
    .wr_data (core_q),
    .rd_en   (pop),
    .rd_data (dataout),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Queued results can never outnumber the credits held for them.
  a_fifo_within_credit: assert property (@(posedge clock) disable iff (!resetn)
    fifo_count <= used);

endmodule

// File: tb/tb_mac2_cyv_issuer.sv
// Bench for mac2_cyv_issuer: behavioural fp32 core, transaction-level
// expectation queue, per-cycle compare, plus directed literal checks.
module tb_mac2_cyv_issuer;

  localparam int LAT   = 15;
  localparam int DEPTH = 32;

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic        ivalid = 1'b0;
  logic        iready = 1'b0;
  logic        oready;
  logic [31:0] datainC = '0, datainA0 = '0, datainB0 = '0, datainA1 = '0, datainB1 = '0;
  logic [31:0] core_c, core_a0, core_b0, core_a1, core_b1, core_q;
  logic        ovalid;
  logic [31:0] dataout;
  logic        busy;
  logic        overflow_err;

  int n_chk  = 0;
  int n_fail = 0;

  mac2_cyv_issuer #(
    .DATA_W     (32),
    .LATENCY    (LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .ivalid       (ivalid),
    .oready       (oready),
    .datainC      (datainC),
    .datainA0     (datainA0),
    .datainB0     (datainB0),
    .datainA1     (datainA1),
    .datainB1     (datainB1),
    .core_c       (core_c),
    .core_a0      (core_a0),
    .core_b0      (core_b0),
    .core_a1      (core_a1),
    .core_b1      (core_b1),
    .core_q       (core_q),
    .ovalid       (ovalid),
    .iready       (iready),
    .dataout      (dataout),
    .busy         (busy),
    .overflow_err (overflow_err)
  );

  always #5 clock = ~clock;

  // fp32 <-> real for normal numbers and zero (all bench operands are such).
  function automatic real fp2real(input logic [31:0] b);
    logic [63:0] d;
    int          ee;
    if (b[30:0] == 31'd0) return 0.0;
    ee = int'(b[30:23]) + 896;
    d  = {b[31], ee[10:0], b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2fp(input real r);
    logic [63:0] d;
    int          ee;
    if (r == 0.0) return 32'd0;
    d  = $realtobits(r);
    ee = int'(d[62:52]) - 896;
    return {d[63], ee[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] mac5(input logic [31:0] c, a0, b0, a1, b1);
    return real2fp(fp2real(c) + fp2real(a0) * fp2real(b0) + fp2real(a1) * fp2real(b1));
  endfunction

  // Behavioural core: free-running, result appears LAT cycles after its inputs.
  logic [31:0] cpipe [LAT];
  always @(posedge clock) begin
    for (int i = LAT - 1; i > 0; i--) cpipe[i] <= cpipe[i-1];
    cpipe[0] <= mac5(core_c, core_a0, core_b0, core_a1, core_b1);
  end
  assign core_q = cpipe[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: each accepted tuple becomes visible at a known cycle.
  typedef struct {
    logic [31:0] res;
    int          rt;
  } exp_t;
  exp_t q[$];
  int   cyc = 0;

  initial begin
    int  cn;
    bit  do_acc, do_pop;
    forever begin
      @(posedge clock or negedge resetn);
      if (!resetn) begin
        q.delete();
      end else begin
        cn     = cyc + 1;
        do_acc = ivalid && (q.size() < DEPTH);
        do_pop = (q.size() != 0) && (q[0].rt <= cyc) && iready;
        if (do_pop) void'(q.pop_front());
        if (do_acc) q.push_back('{res: mac5(datainC, datainA0, datainB0, datainA1, datainB1),
                                  rt: cn + LAT + 1});
        cyc = cn;
      end
    end
  end

  // Per-cycle compare against the model, plus a streaming ovalid monitor.
  bit mon_en = 0;
  int mon_first = -1, mon_last = -1, mon_cnt = 0;
  initial begin
    bit exp_ov;
    forever begin
      @(negedge clock);
      if (resetn) begin
        exp_ov = (q.size() != 0) && (q[0].rt <= cyc);
        chk("ovalid", 32'(ovalid), 32'(exp_ov));
        if (exp_ov && ovalid) chk("dataout", dataout, q[0].res);
        chk("oready", 32'(oready), 32'(q.size() < DEPTH));
        chk("busy", 32'(busy), 32'(q.size() != 0));
        chk("overflow_err", 32'(overflow_err), 32'd0);
        if (mon_en && ovalid) begin
          if (mon_first < 0) mon_first = cyc;
          mon_last = cyc;
          mon_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rand_tuple();
    datainC  = real2fp(real'($urandom_range(0, 15)));
    datainA0 = real2fp(real'($urandom_range(0, 15)));
    datainB0 = real2fp(real'($urandom_range(0, 15)));
    datainA1 = real2fp(real'($urandom_range(0, 15)));
    datainB1 = real2fp(real'($urandom_range(0, 15)));
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (busy && k < 300) begin
      tick();
      k++;
    end
    chk({name, "_drain_timeout"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int k, nacc, nlow, nov;

    // Reset
    #2 resetn = 1'b0;
    #1;
    chk("rst_ovalid", 32'(ovalid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_core_c", core_c, 32'd0);
    chk("rst_core_b1", core_b1, 32'd0);
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    tick();
    chk("rel_oready", 32'(oready), 32'd1);

    // Single op, hand-computed: 0.5 + 1*2 + 3*4 = 14.5
    iready   = 1'b1;
    datainC  = 32'h3F000000;
    datainA0 = 32'h3F800000;
    datainB0 = 32'h40000000;
    datainA1 = 32'h40400000;
    datainB1 = 32'h40800000;
    ivalid   = 1'b1;
    tick();
    ivalid = 1'b0;
    k = 0;
    do begin
      tick();
      k++;
    end while (!ovalid && k < 40);
    chk("single_latency", 32'(k), 32'd16);
    chk("single_data", dataout, 32'h41680000);
    tick();
    chk("single_ovalid_drop", 32'(ovalid), 32'd0);
    chk("single_busy_drop", 32'(busy), 32'd0);

    // Backpressure: fill all credits
    iready = 1'b0;
    nacc   = 0;
    for (int i = 0; i < 40; i++) begin
      rand_tuple();
      ivalid = 1'b1;
      if (oready) nacc++;
      tick();
    end
    chk("bp_accepts", 32'(nacc), 32'd32);
    chk("bp_oready", 32'(oready), 32'd0);
    chk("bp_overflow", 32'(overflow_err), 32'd0);

    // Boundary: full credits, accept and pop requested together
    rand_tuple();
    iready = 1'b1;
    tick();
    chk("bnd_used_full", 32'(dut.used), 32'd31);
    chk("bnd_oready_back", 32'(oready), 32'd1);
    rand_tuple();
    tick();
    chk("bnd_used_31", 32'(dut.used), 32'd31);
    ivalid = 1'b0;
    drain("bp");

    // Streaming: 100 back-to-back tuples with iready held high
    mon_en = 1;
    nlow   = 0;
    for (int i = 0; i < 100; i++) begin
      rand_tuple();
      ivalid = 1'b1;
      if (!oready) nlow++;
      tick();
    end
    ivalid = 1'b0;
    drain("stream");
    mon_en = 0;
    nov    = mon_cnt;
    chk("stream_oready_low", 32'(nlow), 32'd0);
    chk("stream_results", 32'(nov), 32'd100);
    chk("stream_contiguous", 32'(mon_last - mon_first + 1), 32'd100);

    // Reset mid-operation: 8 accepted, 3 landed, 5 in flight
    iready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rand_tuple();
      ivalid = 1'b1;
      tick();
    end
    ivalid = 1'b0;
    repeat (11) tick();
    chk("mid_used", 32'(dut.used), 32'd8);
    chk("mid_fifo_count", 32'(dut.u_fifo.count), 32'd3);
    chk("mid_ovalid", 32'(ovalid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_ovalid", 32'(ovalid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    iready = 1'b1;
    nov = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      tick();
      if (ovalid) nov++;
    end
    chk("post_rst_ovalid", 32'(nov), 32'd0);
    chk("post_rst_oready", 32'(oready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Wrap/random: 3*DEPTH tuples with random ivalid/iready
    nacc = 0;
    k    = 0;
    while (!(nacc == 3 * DEPTH && !busy) && k < 5000) begin
      iready = 1'($urandom_range(0, 1));
      ivalid = (nacc < 3 * DEPTH) ? 1'($urandom_range(0, 1)) : 1'b0;
      rand_tuple();
      if (ivalid && oready) nacc++;
      tick();
      k++;
    end
    ivalid = 1'b0;
    chk("rand_accepts", 32'(nacc), 32'(3 * DEPTH));
    chk("rand_drained", 32'(busy), 32'd0);
    chk("rand_overflow", 32'(overflow_err), 32'd0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
